de2i_150_qsys_led_pwm: RTL and testbench
========================================

Name: de2i_150_qsys_led_pwm

Overview:
- Downstream stage of the 4-bit LED PIO: takes the PIO's out_port pattern on led_in and drives the board LEDs through a brightness PWM and an optional blink gate.
- Its own Avalon-MM slave carries the control, duty and blink registers, so software sets LED on/off through the PIO and appearance through this block.
- Sits between the PIO and the top-level LED pins.

Parameters:
- NUM_LEDS, 4, width of led_in/led_out
- PWM_BITS, 8, PWM counter and duty width
- BLINK_BITS, 24, blink half-period counter width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  combinational read data, zero-extended
- led_in  input  NUM_LEDS  pattern from the LED PIO out_port
- led_out  output  NUM_LEDS  registered LED drive

Behaviour:
- All state is cleared asynchronously while reset=1: ctrl=0, duty_shadow=duty_active=0xFF, blink_half=0, pwm_cnt=0, blink_cnt=0, phase=1, led_out=0.
- A write occurs when chipselect && !write_n; it takes effect on that clk edge.
- Register map:
  - addr0 CTRL: [0] enable, [1] blink_en; read/write.
  - addr1 DUTY: [PWM_BITS-1:0] duty_shadow; read/write. Readback returns the shadow value.
  - addr2 BLINK_HALF: [BLINK_BITS-1:0] half-period in clk cycles; read/write.
  - addr3 STATUS: read-only, writes ignored. [0]=phase, [15:8]=pwm_cnt, [16]=(duty_active==duty_shadow).
- PWM counter:
  - pwm_cnt increments every cycle and wraps 255->0.
  - duty_active loads from duty_shadow only on the cycle where pwm_cnt==255, so duty changes land glitch-free at the period boundary.
  - A write on that same wrap cycle is seen at the following wrap, not the current one.
- pwm_on:
  - duty_active==0xFF -> always 1.
  - Otherwise pwm_on = (pwm_cnt < duty_active). duty_active==0 -> never on.
- Blink:
  - If blink_half==0, phase is held at 1 and blink_cnt is held at 0.
  - Otherwise blink_cnt counts 0..blink_half-1; at blink_half-1 it returns to 0 and phase toggles.
  - Any write to BLINK_HALF forces blink_cnt=0 and phase=1 on the same edge. This also makes shrinking the period below the current count safe.
- gate = pwm_on & (~blink_en | phase).
- Output, registered with 1-cycle latency from led_in/gate to led_out:
  - enable=0: led_out <= led_in (plain bypass).
  - enable=1: led_out <= led_in & {NUM_LEDS{gate}}.
- Clearing enable stops nothing: counters keep running and only the output mux changes.
- Reset asserted mid-operation: led_out goes to 0 immediately (asynchronous). After release the PWM restarts from 0 at full duty.
- readdata is combinational: mux of the selected register, zero-extended to 32 bits.

Test Plan:
- Reset, then led_in=4'b1010, CTRL=0 -> led_out=0 during reset; 4'b1010 one cycle after release and after every led_in change.
- CTRL=1, DUTY=0x40 -> after the next wrap, led_out=1010 for exactly 64 of every 256 cycles, starting at pwm_cnt=0. DUTY=0x00 -> led_out constantly 0. DUTY=0xFF -> constantly 1010.
- Write DUTY=0x80 while pwm_cnt=0x10 -> STATUS[16]=0 until the pwm_cnt==255 cycle; the new duty applies from pwm_cnt=0. Also write on the wrap cycle itself -> applied one period later.
- CTRL=3, DUTY=0xFF, BLINK_HALF=10 -> led_out alternates 10 cycles on / 10 cycles off. A BLINK_HALF=4 write mid-phase -> phase=1 and 4-cycle halves start from the write edge.
- BLINK_HALF=0 with blink_en=1 -> no blinking; STATUS[0]=1 constantly.
- Assert reset asynchronously mid-blink (between clk edges) -> led_out=0 without waiting for a clock edge. All registers read back their reset values: CTRL=0, DUTY=0xFF, BLINK_HALF=0.

Source files
------------

// File: rtl/de2i_150_qsys_led_pwm.sv
// LED appearance stage between the LED PIO and the board LED pins.
// Applies a brightness PWM and an optional blink gate to the PIO pattern.
// Exposes CTRL, DUTY, BLINK_HALF and STATUS registers on an Avalon-MM slave.
module de2i_150_qsys_led_pwm #(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam logic [PWM_BITS-1:0]   PWM_MAX   = '1;
    localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [1:0]            r_ctrl;
    logic [PWM_BITS-1:0]   r_duty_shadow;
    logic [PWM_BITS-1:0]   r_duty_active;
    logic [BLINK_BITS-1:0] r_blink_half;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic                  r_phase;
    logic [NUM_LEDS-1:0]   r_led_out;

    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_duty;
    logic                  w_wr_blink;
    logic                  w_pwm_wrap;
    logic                  w_pwm_on;
    logic                  w_gate;
    logic                  w_blink_last;
    logic                  w_unused;

    assign w_wr       = chipselect && !write_n;
    assign w_wr_ctrl  = w_wr && (address == ADDR_CTRL);
    assign w_wr_duty  = w_wr && (address == ADDR_DUTY);
    assign w_wr_blink = w_wr && (address == ADDR_BLINK);

    assign w_pwm_wrap   = (r_pwm_cnt == PWM_MAX);
    assign w_blink_last = (r_blink_cnt == (r_blink_half - BLINK_ONE));

    // Full-scale duty is a true "always on"; otherwise on while the counter is below duty.
    assign w_pwm_on = (r_duty_active == PWM_MAX) || (r_pwm_cnt < r_duty_active);
    assign w_gate   = w_pwm_on && (!r_ctrl[1] || r_phase);

    assign led_out = r_led_out;

    // writedata bits above the widest register are never stored.
    assign w_unused = ^writedata[31:BLINK_BITS];

    // Software-visible configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl        <= 2'b00;
            r_duty_shadow <= PWM_MAX;
            r_blink_half  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= writedata[1:0];
            end
            if (w_wr_duty) begin
                r_duty_shadow <= writedata[PWM_BITS-1:0];
            end
            if (w_wr_blink) begin
                r_blink_half <= writedata[BLINK_BITS-1:0];
            end
        end
    end

    // Free-running PWM counter; duty is only transferred at the period boundary so
    // a changed duty never produces a truncated or stretched pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt     <= '0;
            r_duty_active <= PWM_MAX;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_pwm_wrap) begin
                r_duty_active <= r_duty_shadow;
            end
        end
    end

    // Blink half-period counter; a BLINK_HALF write restarts the on-phase immediately,
    // which also keeps a shrunken period from running past its new end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_wr_blink) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_half == '0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blink_last) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
        end
    end

    // Registered LED drive: bypass when disabled, gated pattern when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out <= '0;
        end else if (r_ctrl[0]) begin
            r_led_out <= led_in & {NUM_LEDS{w_gate}};
        end else begin
            r_led_out <= led_in;
        end
    end

    // Combinational register readback, zero-extended.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[1:0] = r_ctrl;
            ADDR_DUTY:   readdata[PWM_BITS-1:0] = r_duty_shadow;
            ADDR_BLINK:  readdata[BLINK_BITS-1:0] = r_blink_half;
            ADDR_STATUS: begin
                readdata[0]            = r_phase;
                readdata[8 +: PWM_BITS] = r_pwm_cnt;
                readdata[16]           = (r_duty_active == r_duty_shadow);
            end
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_de2i_150_qsys_led_pwm.sv
// Bench for de2i_150_qsys_led_pwm: cycle-level reference model plus directed scenarios.
module tb_de2i_150_qsys_led_pwm;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  led_in;
    logic [3:0]  led_out;

    int tests;
    int fails;
    bit chk_en;

    de2i_150_qsys_led_pwm dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time-based view of the block.
    // m_t = edges since reset release (pwm_cnt = m_t mod 256),
    // m_since = edges since the last BLINK_HALF write or reset.
    logic [1:0]  m_ctrl;
    logic [7:0]  m_shadow;
    logic [7:0]  m_active;
    logic [31:0] m_half;
    int          m_since;
    int          m_t;
    logic [3:0]  m_led;

    function automatic bit m_phase();
        if (m_half == 0) return 1'b1;
        return ((m_since / int'(m_half)) % 2) == 0;
    endfunction

    function automatic bit m_gate();
        int  pwm;
        bit  on;
        pwm = m_t % 256;
        on  = (m_active == 8'hFF) || (pwm < int'(m_active));
        return on && (!m_ctrl[1] || m_phase());
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, m_ctrl};
            2'd1:    return {24'b0, m_shadow};
            2'd2:    return m_half;
            default: return {15'b0, (m_active == m_shadow), 8'(m_t % 256), 7'b0, m_phase()};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl   <= 2'b00;
            m_shadow <= 8'hFF;
            m_active <= 8'hFF;
            m_half   <= 32'd0;
            m_since  <= 0;
            m_t      <= 0;
            m_led    <= 4'b0000;
        end else begin
            m_led   <= m_ctrl[0] ? (led_in & {4{m_gate()}}) : led_in;
            if ((m_t % 256) == 255) m_active <= m_shadow;
            m_t     <= m_t + 1;
            m_since <= m_since + 1;
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: m_ctrl   <= writedata[1:0];
                    2'd1: m_shadow <= writedata[7:0];
                    2'd2: begin
                        m_half  <= {8'b0, writedata[23:0]};
                        m_since <= 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("led_out_model", {36'b0, led_out}, {36'b0, m_led});
            check("readdata_model", {8'b0, readdata}, {8'b0, model_rd(address)});
        end
    end

    // All drive tasks are entered shortly after a rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_pwm(input logic [7:0] v);
        bit found;
        found   = 1'b0;
        address = 2'd3;
        #1;
        for (int i = 0; i < 600 && !found; i++) begin
            if (readdata[15:8] == v) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("wait_pwm_timeout", {39'b0, found}, 40'd1);
    endtask

    task automatic count_on(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (led_out == 4'b1010) c++;
        end
    endtask

    task automatic sample_bits(input int n, output logic [39:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bits[i] = (led_out == 4'b1010);
        end
    endtask

    int          cnt;
    logic [39:0] pat;

    initial begin
        tests      = 0;
        fails      = 0;
        chk_en     = 1'b0;
        reset      = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        led_in     = 4'b1010;

        #2 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset_led_zero", {36'b0, led_out}, 40'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Bypass with enable=0, one cycle latency.
        @(posedge clk); #1;
        check("bypass_first", {36'b0, led_out}, 40'hA);
        led_in = 4'b0110;
        #1;
        check("bypass_no_comb_path", {36'b0, led_out}, 40'hA);
        @(posedge clk); #1;
        check("bypass_change", {36'b0, led_out}, 40'h6);
        led_in = 4'b1010;
        @(posedge clk); #1;

        // Quarter duty.
        wr(2'd0, 32'd1);
        wr(2'd1, 32'h40);
        #1;
        check("duty_readback", {8'b0, readdata}, 40'h40);
        wait_pwm(8'hFF);
        @(posedge clk); #1;
        count_on(256, cnt);
        check("duty40_on_count", 40'(cnt), 40'd64);

        // Zero duty.
        wr(2'd1, 32'h00);
        wait_pwm(8'hFF);
        @(posedge clk); #1;
        count_on(256, cnt);
        check("duty00_on_count", 40'(cnt), 40'd0);

        // Full duty.
        wr(2'd1, 32'hFF);
        wait_pwm(8'hFF);
        @(posedge clk); #1;
        count_on(256, cnt);
        check("dutyFF_on_count", 40'(cnt), 40'd256);

        // Mid-period duty write waits for the boundary.
        wait_pwm(8'h10);
        wr(2'd1, 32'h80);
        address = 2'd3; #1;
        check("status16_pending", {39'b0, readdata[16]}, 40'd0);
        wait_pwm(8'hFF);
        check("status16_at_wrap", {39'b0, readdata[16]}, 40'd0);
        @(posedge clk); #1;
        check("status16_loaded", {39'b0, readdata[16]}, 40'd1);
        count_on(256, cnt);
        check("duty80_on_count", 40'(cnt), 40'd128);

        // Write on the wrap cycle itself: old duty for one more period.
        wait_pwm(8'hFF);
        wr(2'd1, 32'h20);
        address = 2'd3; #1;
        check("status16_wrap_write", {39'b0, readdata[16]}, 40'd0);
        count_on(256, cnt);
        check("wrap_write_old_duty", 40'(cnt), 40'd128);
        wait_pwm(8'hFF);
        @(posedge clk); #1;
        count_on(256, cnt);
        check("wrap_write_new_duty", 40'(cnt), 40'd32);

        // Blink at full duty.
        wr(2'd1, 32'hFF);
        wait_pwm(8'hFF);
        @(posedge clk); #1;
        wr(2'd0, 32'd3);
        wr(2'd2, 32'd10);
        sample_bits(40, pat);
        check("blink10_pattern", pat, 40'h003FF003FF);
        repeat (3) @(posedge clk);
        #1;
        wr(2'd2, 32'd4);
        sample_bits(16, pat);
        check("blink4_restart", pat, 40'h0000000F0F);

        // BLINK_HALF=0: blinking disabled, phase held high.
        wr(2'd2, 32'd0);
        address = 2'd3; #1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (readdata[0] == 1'b1 && led_out == 4'b1010) cnt++;
        end
        check("blink0_steady", 40'(cnt), 40'd20);

        // Asynchronous reset mid-blink.
        wr(2'd2, 32'd10);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_led", {36'b0, led_out}, 40'h0);
        address = 2'd0; #1;
        check("reset_ctrl", {8'b0, readdata}, 40'h0);
        address = 2'd1; #1;
        check("reset_duty", {8'b0, readdata}, 40'hFF);
        address = 2'd2; #1;
        check("reset_blink", {8'b0, readdata}, 40'h0);
        address = 2'd3; #1;
        check("reset_status", {8'b0, readdata}, 40'h10001);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_bypass", {36'b0, led_out}, 40'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
